serdes_frame_aligner: RTL
=========================

// Module: serdes_frame_aligner
// PURPOSE
//   Multi-channel word aligner for ISERDES-based LVDS ADC capture, in the CLKDIV domain.
//   Compares the deserialised frame-clock word with FRAME_PATTERN and pulses BITSLIP,
//   shared by all channel deserialisers, until the word matches. Declares lock after
//   MATCH_CNT consecutive matches, then passes aligned channel words with a valid flag.
// PARAMETERS
//   NUM_CH        4      number of data channels
//   WIDTH         8      deserialisation ratio / word width (2..14)
//   FRAME_PATTERN 8'hF0  expected frame word (WIDTH bits)
//   SETTLE_CYC    4      wait cycles after a BITSLIP pulse before re-checking (>=3)
//   MATCH_CNT     16     consecutive matches needed for lock (>=1)
//   MISS_LIMIT    4      consecutive misses that drop lock (auto-relock build only)
// PORTS
//   CLKDIV      in   1              divided clock; all logic on rising edge
//   RST         in   1              asynchronous, active-high reset
//   ALIGN_START in   1              one-cycle pulse: restart alignment
//   FRAME_Q     in   WIDTH          frame-channel deserialiser word
//   DATA_Q      in   NUM_CH*WIDTH   channel words; ch k = [k*WIDTH +: WIDTH]
//   BITSLIP     out  1              one-cycle slip request to all deserialisers
//   DATA_OUT    out  NUM_CH*WIDTH   registered DATA_Q
//   DATA_VALID  out  1              high while locked; aligned with DATA_OUT
//   LOCKED      out  1              alignment achieved
//   ALIGN_ERR   out  1              no matching slip position found
//   SLIP_COUNT  out  $clog2(WIDTH)+1  BITSLIP pulses issued since the last (re)start
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; slip, settle and match counters 0.
//   All outputs are registered. BITSLIP is high exactly for the cycle the FSM is in SLIP.
//   FSM:
//     IDLE   -> CHECK unconditionally on the first clock after RST is released.
//     CHECK  FRAME_Q==FRAME_PATTERN -> VERIFY, match=1;
//            else slip_cnt==WIDTH -> ERROR; else -> SLIP.
//     SLIP   BITSLIP=1, slip_cnt+1 -> SETTLE, settle counter loaded with SETTLE_CYC.
//     SETTLE count down; at 0 -> CHECK. Ignores FRAME_Q.
//     VERIFY match -> match+1, and at MATCH_CNT -> LOCKED;
//            miss -> SLIP if slip_cnt<WIDTH, else ERROR. match cleared on a miss.
//     LOCKED LOCKED=1, DATA_VALID=1. Exits only by ALIGN_START/RST, or by auto-relock.
//     ERROR  ALIGN_ERR=1. Sticky until ALIGN_START or RST.
//   ALIGN_START has priority in every state, including SLIP:
//     clears slip/match counters, LOCKED, DATA_VALID, ALIGN_ERR -> SETTLE(SETTLE_CYC).
//     No BITSLIP is issued on the cycle after ALIGN_START.
//   MATCH_CNT=1: the first CHECK match goes straight to LOCKED, bypassing VERIFY.
//   DATA_OUT <= DATA_Q every cycle in all states (latency 1).
//     DATA_VALID/LOCKED change on the same edge as the corresponding DATA_OUT word.
//   SLIP_COUNT saturates at WIDTH and holds its value in LOCKED and ERROR.
//   A full WIDTH-slip sweep covers every word phase, including DDR odd/even slip behaviour.
// CONFIGURATION
//   SERDES_ALIGN_AUTO_RELOCK_EN defined:
//     in LOCKED, a miss counter counts consecutive FRAME_Q mismatches; a match clears it.
//     Reaching MISS_LIMIT: LOCKED, DATA_VALID <= 0, slip_cnt <= 0 -> CHECK.
//   Not defined: no miss counter; LOCKED ignores FRAME_Q and is sticky.
// TESTING (bench models a deserialiser: BITSLIP rotates word by 1 bit, 2-cycle latency)
//   1 Frame pre-aligned 0xF0 -> 0 BITSLIP pulses; LOCKED=1 on cycle 17 after first CHECK;
//     SLIP_COUNT=0.
//   2 Frame offset 3 bits -> exactly 3 BITSLIP pulses, each 1 cycle and >=5 cycles apart;
//     LOCKED=1; SLIP_COUNT=3; DATA_OUT equals the rotated DATA_Q, 1 cycle late.
//   3 FRAME_Q fixed 0x00 -> 8 BITSLIP pulses then ALIGN_ERR=1, LOCKED=0, SLIP_COUNT=8;
//     ALIGN_START then clears ALIGN_ERR.
//   4 Single miss at match 10 during VERIFY -> one extra BITSLIP, match restarts;
//     RST mid-SETTLE -> all outputs 0 at once.
//   5 ALIGN_START while LOCKED and while in SLIP -> LOCKED/DATA_VALID=0 next cycle;
//     no BITSLIP for the next SETTLE_CYC+1 cycles; relock completes.
//   6 AUTO_RELOCK_EN: 3 misses then 1 match -> stays LOCKED;
//     4 consecutive misses -> LOCKED=0, realignment. Without the macro -> stays LOCKED.

Source files
------------

// File: rtl/serdes_frame_aligner.sv
// Frame-word aligner for ISERDES LVDS ADC capture: slips every channel until the frame word matches.
// Optional SERDES_ALIGN_AUTO_RELOCK_EN: drop lock and realign after MISS_LIMIT consecutive frame misses.
module serdes_frame_aligner #(
    parameter int               NUM_CH        = 4,
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] FRAME_PATTERN = 8'hF0,
    parameter int               SETTLE_CYC    = 4,
    parameter int               MATCH_CNT     = 16,
    parameter int               MISS_LIMIT    = 4
) (
    input  logic                      CLKDIV,
    input  logic                      RST,
    input  logic                      ALIGN_START,
    input  logic [WIDTH-1:0]          FRAME_Q,
    input  logic [NUM_CH*WIDTH-1:0]   DATA_Q,
    output logic                      BITSLIP,
    output logic [NUM_CH*WIDTH-1:0]   DATA_OUT,
    output logic                      DATA_VALID,
    output logic                      LOCKED,
    output logic                      ALIGN_ERR,
    output logic [$clog2(WIDTH):0]    SLIP_COUNT
);

    localparam int SCW = $clog2(WIDTH) + 1;
    localparam int MW  = $clog2(MATCH_CNT + 1);
    localparam int STW = $clog2(SETTLE_CYC + 1);

    if (WIDTH < 2 || WIDTH > 14 || SETTLE_CYC < 3 || MATCH_CNT < 1 || MISS_LIMIT < 1) begin : g_bad_param
        $error("serdes_frame_aligner: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SLIP, S_SETTLE, S_VERIFY, S_LOCKED, S_ERROR
    } state_t;

    state_t         state, state_n;
    logic [SCW-1:0] slip_cnt, slip_n;
    logic [MW-1:0]  match_cnt, match_n;
    logic [STW-1:0] settle_cnt, settle_n;
    logic           hit;

`ifdef SERDES_ALIGN_AUTO_RELOCK_EN
    localparam int MSW = $clog2(MISS_LIMIT + 1);
    logic [MSW-1:0] miss_cnt, miss_n;
`endif

    assign hit        = (FRAME_Q == FRAME_PATTERN);
    assign SLIP_COUNT = slip_cnt;

    always_comb begin
        state_n  = state;
        slip_n   = slip_cnt;
        match_n  = match_cnt;
        settle_n = settle_cnt;
`ifdef SERDES_ALIGN_AUTO_RELOCK_EN
        miss_n   = miss_cnt;
`endif
        if (ALIGN_START) begin
            // restart wins over everything, including a slip in flight
            slip_n   = '0;
            match_n  = '0;
            settle_n = STW'(SETTLE_CYC);
            state_n  = S_SETTLE;
`ifdef SERDES_ALIGN_AUTO_RELOCK_EN
            miss_n   = '0;
`endif
        end else begin
            case (state)
                S_IDLE: state_n = S_CHECK;
                S_CHECK: begin
                    if (hit) begin
                        match_n = MW'(1);
                        state_n = (MATCH_CNT == 1) ? S_LOCKED : S_VERIFY;
                    end else if (slip_cnt == SCW'(WIDTH)) begin
                        state_n = S_ERROR;
                    end else begin
                        state_n = S_SLIP;
                    end
                end
                S_SLIP: begin
                    if (slip_cnt != SCW'(WIDTH)) slip_n = slip_cnt + SCW'(1);
                    settle_n = STW'(SETTLE_CYC);
                    state_n  = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) state_n = S_CHECK;
                    else                  settle_n = settle_cnt - STW'(1);
                end
                S_VERIFY: begin
                    if (hit) begin
                        match_n = match_cnt + MW'(1);
                        if (match_n == MW'(MATCH_CNT)) state_n = S_LOCKED;
                    end else begin
                        match_n = '0;
                        state_n = (slip_cnt < SCW'(WIDTH)) ? S_SLIP : S_ERROR;
                    end
                end
                S_LOCKED: begin
`ifdef SERDES_ALIGN_AUTO_RELOCK_EN
                    if (hit) begin
                        miss_n = '0;
                    end else if (miss_cnt + MSW'(1) == MSW'(MISS_LIMIT)) begin
                        miss_n  = '0;
                        slip_n  = '0;
                        match_n = '0;
                        state_n = S_CHECK;
                    end else begin
                        miss_n = miss_cnt + MSW'(1);
                    end
`endif
                end
                S_ERROR: state_n = S_ERROR;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLKDIV or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_n;
    end

    // flags decode the next state so they line up with the FSM state they describe
    always_ff @(posedge CLKDIV or posedge RST) begin
        if (RST) begin
            slip_cnt   <= '0;
            match_cnt  <= '0;
            settle_cnt <= '0;
            BITSLIP    <= 1'b0;
            LOCKED     <= 1'b0;
            DATA_VALID <= 1'b0;
            ALIGN_ERR  <= 1'b0;
            DATA_OUT   <= '0;
        end else begin
            slip_cnt   <= slip_n;
            match_cnt  <= match_n;
            settle_cnt <= settle_n;
            BITSLIP    <= (state_n == S_SLIP);
            LOCKED     <= (state_n == S_LOCKED);
            DATA_VALID <= (state_n == S_LOCKED);
            ALIGN_ERR  <= (state_n == S_ERROR);
            DATA_OUT   <= DATA_Q;
        end
    end

`ifdef SERDES_ALIGN_AUTO_RELOCK_EN
    always_ff @(posedge CLKDIV or posedge RST) begin
        if (RST) miss_cnt <= '0;
        else     miss_cnt <= miss_n;
    end
`endif

endmodule
